// File: rtl/divide_seq.sv
// divide_seq: multi-cycle restoring divider, STEPS quotient bits per clock,
// signed/unsigned operands with divide-by-zero detection.
module divide_seq #(
  parameter int WIDTH = 8,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  if (WIDTH % STEPS != 0 || WIDTH < 2) begin : g_bad_params
    $error("divide_seq: WIDTH must be >=2 and a multiple of STEPS");
  end
  typedef enum logic {IDLE, DIV} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, b_q, b_d, quo_q, quo_d, remo_q, remo_d;
  logic [WIDTH:0]   r_q, r_d, sh;
  logic [WIDTH+1:0] diff;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qn_q, qn_d, rn_q, rn_d, done_q, done_d, dbz_q, dbz_d;
  logic             a_neg, b_neg;
  assign a_neg = signed_mode & dividend[WIDTH-1];
  assign b_neg = signed_mode & divisor[WIDTH-1];
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    b_d     = b_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    qn_d    = qn_q;
    rn_d    = rn_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    sh      = '0;
    diff    = '0;
    if (state_q == IDLE) begin
      if (start && divisor == '0) begin
        done_d = 1'b1;
        dbz_d  = 1'b1;
        quo_d  = '1;
        remo_d = dividend;
      end else if (start) begin
        state_d = DIV;
        q_d     = a_neg ? -dividend : dividend;
        b_d     = b_neg ? -divisor : divisor;
        qn_d    = a_neg ^ b_neg;
        rn_d    = a_neg;
        r_d     = '0;
        cnt_d   = '0;
      end
    end else begin
      // q_d doubles as the dividend shifter: its MSB feeds the remainder
      for (int i = 0; i < STEPS; i++) begin
        sh   = {r_d[WIDTH-1:0], q_d[WIDTH-1]};
        diff = {1'b0, sh} - {2'b00, b_q};
        r_d  = diff[WIDTH+1] ? sh : diff[WIDTH:0];
        q_d  = {q_d[WIDTH-2:0], ~diff[WIDTH+1]};
      end
      cnt_d = cnt_q + CW'(STEPS);
      if (cnt_d == CW'(WIDTH)) begin
        state_d = IDLE;
        done_d  = 1'b1;
        dbz_d   = 1'b0;
        quo_d   = qn_q ? -q_d : q_d;
        remo_d  = rn_q ? -r_d[WIDTH-1:0] : r_d[WIDTH-1:0];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      qn_q    <= 1'b0;
      rn_q    <= 1'b0;
      quo_q   <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      qn_q    <= qn_d;
      rn_q    <= rn_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end
  assign busy        = state_q == DIV;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;
endmodule
